// File: rtl/lfsr_misr_bist.sv
// lfsr_misr_bist: Galois LFSR pattern generator driving a CUT, MISR compacting its responses
// into a signature that is compared against a golden value.
module lfsr_misr_bist #(
    parameter int                TPG_W        = 4,
    parameter int                MISR_W       = 4,
    parameter logic [TPG_W-1:0]  TPG_POLY     = 4'b1100,
    parameter logic [MISR_W-1:0] MISR_POLY    = 4'b1100,
    parameter logic [TPG_W-1:0]  SEED         = 1,
    parameter int                NUM_PATTERNS = 15,
    parameter int                LATENCY      = 0,
    parameter logic [MISR_W-1:0] GOLDEN       = '0
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_start,
    input  logic                                i_abort,
    output logic [TPG_W-1:0]                    o_tpg_out,
    input  logic [MISR_W-1:0]                   i_cut_resp,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_pass,
    output logic [MISR_W-1:0]                   o_signature,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   o_pat_cnt
);
    localparam int CW = $clog2(NUM_PATTERNS + 1);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [TPG_W-1:0] SEED_E = (SEED == '0) ? TPG_W'(1) : SEED;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE_ST} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TPG_W-1:0]    r_lfsr;
    logic [MISR_W-1:0]   r_misr;
    logic [CW-1:0]       r_pat_cnt;
    logic [1:0]          r_fl_cnt;
    logic                r_pass;
    logic                w_load;
    logic                w_last;
    logic                w_fl_last;
    logic                w_valid;
    logic                w_step_m;
    logic [TPG_W-1:0]    w_lfsr_nxt;
    logic [MISR_W-1:0]   w_misr_nxt;
    logic [MISR_W-1:0]   w_misr_d;

    assign w_load     = (r_state == IDLE || r_state == DONE_ST) && i_start && !i_abort;
    assign w_last     = int'(r_pat_cnt) == NUM_PATTERNS - 1;
    assign w_fl_last  = int'(r_fl_cnt) == LATENCY - 1;
    // Responses become valid LATENCY cycles after the first pattern.
    assign w_valid    = int'(r_pat_cnt) >= LATENCY;
    assign w_step_m   = (r_state == RUN && w_valid) || r_state == FLUSH;
    assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TPG_POLY : '0);
    assign w_misr_nxt = ((r_misr >> 1) ^ (r_misr[0] ? MISR_POLY : '0)) ^ i_cut_resp;
    assign w_misr_d   = w_step_m ? w_misr_nxt : r_misr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE_ST: w_state_nxt = w_load ? RUN : r_state;
            RUN:           w_state_nxt = i_abort ? IDLE : w_last ? ((LATENCY > 0) ? FLUSH : DONE_ST) : RUN;
            FLUSH:         w_state_nxt = i_abort ? IDLE : w_fl_last ? DONE_ST : FLUSH;
            default:       w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == RUN) || (r_state == FLUSH);
        o_done = (r_state == DONE_ST);
    end

    // Abort freezes the datapath so the partial signature and count stay visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr    <= SEED_E;
            r_misr    <= '0;
            r_pat_cnt <= '0;
            r_fl_cnt  <= '0;
            r_pass    <= 1'b0;
        end else if (w_load) begin
            r_lfsr    <= SEED_E;
            r_misr    <= '0;
            r_pat_cnt <= '0;
            r_fl_cnt  <= '0;
            r_pass    <= 1'b0;
        end else if (!i_abort) begin
            if (r_state == RUN) begin
                r_lfsr    <= w_lfsr_nxt;
                r_pat_cnt <= r_pat_cnt + 1'b1;
            end
            if (r_state == FLUSH)
                r_fl_cnt <= r_fl_cnt + 2'd1;
            r_misr <= w_misr_d;
            if (w_state_nxt == DONE_ST && r_state != DONE_ST)
                r_pass <= (w_misr_d == GOLDEN);
        end
    end

    assign o_tpg_out   = r_lfsr;
    assign o_signature = r_misr;
    assign o_pat_cnt   = r_pat_cnt;
    assign o_pass      = r_pass;
endmodule

// File: tb/tb_lfsr_misr_bist.sv
// tb_lfsr_misr_bist: directed bench; run results go through a scoreboard queue checked on DONE.
module tb_lfsr_misr_bist;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b, abort, loop0;
    int   tests = 0;
    int   fails = 0;

    logic [3:0] tpg0, tpg1, tpg2, tpg3, sig0, sig1, sig2, sig3, cut0, d1, d2, cnt0;
    logic [1:0] cnt1, cnt2, cnt3;
    logic busy0, busy1, busy2, busy3, done0, done1, done2, done3, pass0, pass1, pass2, pass3;

    assign cut0 = loop0 ? tpg0 : 4'h0;
    always @(posedge clk) begin
        d1 <= tpg3;
        d2 <= d1;
    end

    lfsr_misr_bist u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_abort(abort), .o_tpg_out(tpg0),
        .i_cut_resp(cut0), .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_signature(sig0), .o_pat_cnt(cnt0));
    lfsr_misr_bist #(.NUM_PATTERNS(3), .LATENCY(0), .GOLDEN(4'b0110)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_abort(1'b0), .o_tpg_out(tpg1),
        .i_cut_resp(tpg1), .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_signature(sig1), .o_pat_cnt(cnt1));
    lfsr_misr_bist #(.NUM_PATTERNS(3), .LATENCY(0), .GOLDEN(4'b0000)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_abort(1'b0), .o_tpg_out(tpg2),
        .i_cut_resp(tpg2), .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_signature(sig2), .o_pat_cnt(cnt2));
    lfsr_misr_bist #(.NUM_PATTERNS(3), .LATENCY(2), .GOLDEN(4'b0110)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_abort(1'b0), .o_tpg_out(tpg3),
        .i_cut_resp(d2), .o_busy(busy3), .o_done(done3), .o_pass(pass3), .o_signature(sig3), .o_pat_cnt(cnt3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         id;
        logic [3:0] sig;
        logic       pass;
        logic [3:0] cnt;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;

    logic [3:0] done_v, done_p = '0;
    logic [3:0] sig_v[4], cnt_v[4];
    logic [3:0] pass_v;
    assign done_v = {done3, done2, done1, done0};
    assign pass_v = {pass3, pass2, pass1, pass0};
    assign sig_v  = '{sig0, sig1, sig2, sig3};
    assign cnt_v  = '{cnt0, {2'b0, cnt1}, {2'b0, cnt2}, {2'b0, cnt3}};

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] && !done_p[i]) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: inst %0d, no run expected", i);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_inst", i, e.id);
                    chk("sb_signature", sig_v[i], e.sig);
                    chk("sb_pass", pass_v[i], e.pass);
                    chk("sb_pat_cnt", cnt_v[i], e.cnt);
                end
            end
        end
        done_p <= done_v;
    end

    task automatic wait_idle(output int n);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [3:0] seq[15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
    logic [3:0] mtr[4]  = '{4'h0, 4'h1, 4'h0, 4'h6};
    int n, b3;

    initial begin
        rst_n = 0; start_a = 0; start_b = 0; abort = 0; loop0 = 0;
        repeat (2) @(negedge clk);
        chk("rst_tpg", tpg0, 4'h1);
        chk("rst_sig", sig0, 4'h0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_busy_done_pass", {busy0, done0, pass0}, 3'b000);
        rst_n = 1;
        @(negedge clk);

        // tied-zero run: full LFSR sequence, START pulse mid-run must be ignored
        sb_q.push_back('{0, 4'h0, 1'b1, 4'd15});
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        n = 0;
        while (busy0 && n < 40) begin
            if (n < 15) chk("tpg_seq", tpg0, seq[n]);
            start_a = (n == 3);
            n++;
            @(negedge clk);
        end
        start_a = 0;
        chk("busy_cycles", n, 15);
        chk("tpg_wrap", tpg0, 4'h1);
        chk("done_tied0", {done0, pass0, sig0, cnt0}, {2'b11, 4'h0, 4'd15});

        // loopback twice: identical signatures, DONE drops right after restart
        loop0 = 1;
        for (int r = 0; r < 2; r++) begin
            sb_q.push_back('{0, 4'h2, 1'b0, 4'd15});
            start_a = 1;
            @(negedge clk);
            start_a = 0;
            chk("done_drop", {done0, busy0}, 2'b01);
            wait_idle(n);
            chk("busy_cycles_loop", n, 15);
        end
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_in_done", {done0, sig0}, {1'b1, 4'h2});

        // abort at pattern 5, then coincident START+ABORT
        loop0 = 0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        n = 0;
        while (cnt0 != 4'd5 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("reach_pat5", cnt0, 4'd5);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_state", {busy0, done0, cnt0, tpg0}, {2'b00, 4'd5, 4'hA});
        start_a = 1; abort = 1;
        @(negedge clk);
        start_a = 0; abort = 0;
        chk("start_abort", {busy0, done0, cnt0}, {2'b00, 4'd5});

        // three-pattern loopback, with and without latency
        sb_q.push_back('{1, 4'h6, 1'b1, 4'd3});
        sb_q.push_back('{2, 4'h6, 1'b0, 4'd3});
        sb_q.push_back('{3, 4'h6, 1'b1, 4'd3});
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        b3 = 0;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) chk("misr_trace", sig1, mtr[j]);
            if (j == 3 || j == 4) chk("tpg_frozen", tpg3, 4'h3);
            b3 += int'(busy3);
            @(negedge clk);
        end
        chk("busy_cycles_lat", b3, 5);
        chk("sig_lat", sig3, 4'h6);

        // asynchronous reset mid-run
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst", {busy0, done0, pass0, tpg0, sig0, cnt0}, {3'b000, 4'h1, 4'h0, 4'h0});
        @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        chk("no_done_after_rst", {busy0, done0}, 2'b00);
        chk("sb_left", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
